// File: rtl/aes_pkg.sv
// Shared AES key-path constants: widths, round count and the round-key
// sequencer state encoding.
package aes_pkg;

  localparam int AES_KEY_W      = 128;
  localparam int AES_ADDR_W     = 4;
  localparam int AES_NUM_ROUNDS = 10;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_FETCH   = 2'd1;
  localparam logic [1:0] ST_PRESENT = 2'd2;
  localparam logic [1:0] ST_FIN     = 2'd3;

endpackage

// File: rtl/round_key_sequencer.sv
// Walks the round-key memory in encrypt or decrypt order and streams each
// registered key, tagged with its round index and a last flag, over valid/ready.
//
// state   | meaning
// IDLE    | waiting for start; outputs quiet
// FETCH   | first key being captured from the memory
// PRESENT | key_out valid; next key captured on each handshake
// FIN     | final key accepted; done pulses, then back to IDLE
module round_key_sequencer
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int KEY_W      = AES_KEY_W,
  parameter int ADDR_W     = AES_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              decrypt,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [KEY_W-1:0]  mem_data,
  output logic [KEY_W-1:0]  key_out,
  output logic              key_valid,
  input  logic              key_ready,
  output logic [ADDR_W-1:0] key_round,
  output logic              key_last,
  output logic              busy,
  output logic              done
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_ROUNDS);
  localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              dir_q, dir_d;
  logic [KEY_W-1:0]  key_q, key_d;
  logic [ADDR_W-1:0] round_q, round_d;
  logic              last_q, last_d;
  logic              valid_q, valid_d;

  logic [ADDR_W-1:0] end_ptr;
  logic [ADDR_W-1:0] ptr_step;
  logic              at_end;
  logic              capture;

  // The pointer clamps at the end address so it never leaves 0..NUM_ROUNDS.
  assign end_ptr  = dir_q ? '0 : LAST_ADDR;
  assign at_end   = (ptr_q == end_ptr);
  assign ptr_step = at_end ? ptr_q : (dir_q ? ptr_q - ONE : ptr_q + ONE);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    dir_d   = dir_q;
    key_d   = key_q;
    round_d = round_q;
    last_d  = last_q;
    valid_d = valid_q;
    capture = 1'b0;

    case (state_q)
      ST_IDLE: begin
        valid_d = 1'b0;
        if (start) begin
          dir_d   = decrypt;
          ptr_d   = decrypt ? LAST_ADDR : '0;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: begin
        capture = 1'b1;
        state_d = ST_PRESENT;
      end
      ST_PRESENT: begin
        if (valid_q && key_ready) begin
          if (last_q) begin
            valid_d = 1'b0;
            state_d = ST_FIN;
          end else begin
            capture = 1'b1;
          end
        end
      end
      ST_FIN: begin
        state_d = ST_IDLE;
      end
      default: begin
        valid_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase

    if (capture) begin
      key_d   = mem_data;
      round_d = ptr_q;
      last_d  = at_end;
      valid_d = 1'b1;
      ptr_d   = ptr_step;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      dir_q   <= 1'b0;
      key_q   <= '0;
      round_q <= '0;
      last_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dir_q   <= dir_d;
      key_q   <= key_d;
      round_q <= round_d;
      last_q  <= last_d;
      valid_q <= valid_d;
    end
  end

  assign mem_addr  = ptr_q;
  assign key_out   = key_q;
  assign key_valid = valid_q;
  assign key_round = round_q;
  assign key_last  = last_q;
  assign busy      = (state_q == ST_FETCH) || (state_q == ST_PRESENT);
  assign done      = (state_q == ST_FIN);

endmodule

// File: tb/tb_round_key_sequencer.sv
// Directed/randomized bench: a key-memory model plus an expected round-order
// queue scoreboards every handshake, hold period, done pulse and reset abort.
module tb_round_key_sequencer;

  localparam int NR = 10;
  localparam int KW = 128;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          decrypt;
  logic [AW-1:0] mem_addr;
  logic [KW-1:0] mem_data;
  logic [KW-1:0] key_out;
  logic          key_valid;
  logic          key_ready;
  logic [AW-1:0] key_round;
  logic          key_last;
  logic          busy;
  logic          done;

  logic [KW-1:0] mem [16];

  int n_vec = 0;
  int n_err = 0;

  assign mem_data = mem[mem_addr];

  always #5 clk = ~clk;

  round_key_sequencer #(.NUM_ROUNDS(NR), .KEY_W(KW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .decrypt   (decrypt),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .key_out   (key_out),
    .key_valid (key_valid),
    .key_ready (key_ready),
    .key_round (key_round),
    .key_last  (key_last),
    .busy      (busy),
    .done      (done)
  );

  task automatic chk(input string tag, input logic [KW-1:0] obs, input logic [KW-1:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, "_key_out"}, key_out, '0);
    chk({tag, "_valid"}, key_valid, 1'b0);
    chk({tag, "_round"}, key_round, '0);
    chk({tag, "_last"}, key_last, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_addr"}, mem_addr, '0);
  endtask

  // mode 0: ready held high; 1: ready pattern 1,0,0,1; 2: random ready.
  task automatic run_stream(input bit dec, input int mode, input bit fin_start);
    int            exp_q[$];
    bit            held;
    bit            finished;
    logic [KW-1:0] held_key;
    int            held_round;
    held = 1'b0;
    finished = 1'b0;
    held_key = '0;
    held_round = 0;
    for (int r = 0; r <= NR; r++) exp_q.push_back(dec ? NR - r : r);

    start = 1'b1; decrypt = dec; key_ready = 1'b0;
    step();
    start = 1'b0;
    chk("fetch_valid", key_valid, 1'b0);
    chk("fetch_busy", busy, 1'b1);
    chk("fetch_addr", mem_addr, exp_q[0]);
    step();
    chk("first_valid", key_valid, 1'b1);

    for (int cyc = 0; cyc < 300; cyc++) begin
      bit rdy;
      int r;
      chk("addr_range", mem_addr <= NR, 1'b1);
      if (held) begin
        chk("hold_key", key_out, held_key);
        chk("hold_round", key_round, held_round);
      end
      if (mode == 0) begin
        rdy = 1'b1;
        chk("b2b_valid", key_valid, 1'b1);
      end else if (mode == 1) begin
        rdy = ((cyc % 4) == 0) || ((cyc % 4) == 3);
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      key_ready = rdy;
      start = 1'($urandom_range(0, 1));
      decrypt = 1'($urandom_range(0, 1));
      if (key_valid && rdy) begin
        r = exp_q.pop_front();
        chk("key_round", key_round, r);
        chk("key_out", key_out, mem[r]);
        chk("key_last", key_last, exp_q.size() == 0);
        chk("busy_stream", busy, 1'b1);
        chk("done_early", done, 1'b0);
        held = 1'b0;
      end else begin
        held = key_valid;
        held_key = key_out;
        held_round = int'(key_round);
      end
      step();
      if (exp_q.size() == 0) begin
        finished = 1'b1;
        break;
      end
    end
    chk("stream_complete", finished, 1'b1);

    chk("done_pulse", done, 1'b1);
    chk("fin_busy", busy, 1'b0);
    chk("fin_valid", key_valid, 1'b0);
    start = fin_start; decrypt = 1'b0; key_ready = 1'b0;
    step();
    start = 1'b0;
    chk("done_clear", done, 1'b0);
    chk("idle_busy", busy, 1'b0);
    chk("idle_valid", key_valid, 1'b0);
  endtask

  task automatic run_abort();
    start = 1'b1; decrypt = 1'b0; key_ready = 1'b1;
    step();
    start = 1'b0;
    step();
    for (int k = 0; k <= 4; k++) begin
      chk("abort_round", key_round, k);
      chk("abort_key", key_out, mem[k]);
      step();
    end
    rst = 1'b1;
    step();
    rst = 1'b0; key_ready = 1'b0;
    chk_quiet("abort_rst");
    for (int k = 0; k < 5; k++) begin
      step();
      chk("abort_no_done", done, 1'b0);
      chk("abort_idle", busy, 1'b0);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; decrypt = 1'b0; key_ready = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    mem[0]  = 128'h54776F204F6E65204E696E652054776F;
    mem[1]  = 128'h03610938AACE8EA1F749B765EEAD464F;
    mem[9]  = {32'h9F231CAD, mem[9][95:16], 16'hCB36};
    mem[10] = 128'h1D6DBBABCFB7988D8EF912F76883CDC1;

    step();
    step();
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      chk_quiet("reset_idle");
      step();
    end

    run_stream(1'b0, 0, 1'b0);
    run_stream(1'b1, 0, 1'b0);
    run_stream(1'b0, 1, 1'b1);
    run_stream(1'b1, 2, 1'b0);
    run_abort();
    run_stream(1'b0, 0, 1'b0);
    for (int i = 0; i < 4; i++) run_stream(1'($urandom_range(0, 1)), 2, 1'($urandom_range(0, 1)));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/round_key_sequencer.md
Name: round_key_sequencer

Overview:
- Sits directly downstream of the 16 x 128-bit round-key memory (combinational read: 4-bit address in, 128-bit data out).
- On a start request, walks memory addresses 0..NUM_ROUNDS for encryption, or NUM_ROUNDS..0 for decryption.
- Registers each round key and streams it to the AES round datapath over a valid/ready handshake, at up to one key per cycle.
- Tags each key with its round index and a last flag.

Parameters:
- NUM_ROUNDS, 10, index of the final round key; the sequence is NUM_ROUNDS+1 keys; legal range 1..15.
- KEY_W, 128, round-key width in bits.
- ADDR_W, 4, key-memory address width.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request a key sequence; accepted only in IDLE.
- decrypt  in  1  sampled with an accepted start; 1 = descending order.
- mem_addr  out  ADDR_W  address to the key memory.
- mem_data  in  KEY_W  combinational read data, mem[mem_addr].
- key_out  out  KEY_W  registered round key.
- key_valid  out  1  key_out/key_round/key_last are valid.
- key_ready  in  1  consumer accepts the key when key_valid && key_ready.
- key_round  out  ADDR_W  memory index of key_out.
- key_last  out  1  key_out is the final key of the sequence.
- busy  out  1  sequence in progress.
- done  out  1  one-cycle pulse after the final key is accepted.

Behaviour:
- Reset (rst high at an edge) has priority over everything:
  - state = IDLE; ptr = 0; dir = 0.
  - key_out = 0, key_valid = 0, key_round = 0, key_last = 0, busy = 0, done = 0.
  - Applies mid-sequence too: the sequence is abandoned and no done pulse is issued.
- mem_addr = ptr at all times (registered pointer, no combinational path from inputs). mem_data is used only in the cycle it is captured.
- States are IDLE, FETCH, PRESENT, FIN.
- IDLE:
  - busy = 0, key_valid = 0.
  - On start: dir = decrypt; ptr = decrypt ? NUM_ROUNDS : 0; go to FETCH.
- FETCH (one cycle):
  - busy = 1.
  - At the edge: key_out = mem_data; key_round = ptr; key_last = (ptr == end); key_valid = 1; go to PRESENT.
  - end = NUM_ROUNDS when dir = 0, and 0 when dir = 1.
  - ptr advances to next = dir ? ptr-1 : ptr+1, unless ptr == end.
- PRESENT:
  - busy = 1, key_valid = 1.
  - No handshake: key_out, key_round and key_last hold stable indefinitely.
  - Handshake with key_last = 0: capture mem_data at the current ptr into key_out/key_round/key_last the same edge; key_valid stays 1 (back-to-back, no bubble); ptr advances as in FETCH.
  - Handshake with key_last = 1: key_valid = 0, busy = 0, go to FIN.
- FIN (one cycle):
  - done = 1, then return to IDLE.
  - start is ignored in FIN. The earliest new start is accepted in the cycle after done.
- start or decrypt changes while not in IDLE: ignored; the running sequence is unaffected.
- Latency:
  - start accepted at edge N → key_valid high after edge N+1, showing the first key.
  - With key_ready held 1, all NUM_ROUNDS+1 keys transfer on consecutive cycles.
  - done is high in the cycle after the final handshake.
- Pointer never wraps: ptr is clamped at end. Addresses above NUM_ROUNDS are never driven. For NUM_ROUNDS = 10, addresses 11..15 are never read.
- key_round width is ADDR_W; no arithmetic overflow is possible within the legal parameter range.

Decomposition:
- Shared package aes_pkg holds:
  - AES_KEY_W = 128, AES_ADDR_W = 4, AES_NUM_ROUNDS = 10.
  - The state encoding constants for IDLE/FETCH/PRESENT/FIN.
- No sub-module. The key memory is instantiated beside this block by the parent, not inside it.

Test Plan:
- Reset then idle: rst high 2 cycles, start low → all outputs 0 and mem_addr = 0 held for 10 cycles.
- Encrypt stream, key_ready = 1: start = 1, decrypt = 0 → 11 consecutive valid keys.
  - First key_out = 54776F204F6E65204E696E652054776F, round 0.
  - Round 1 key = 03610938AACE8EA1F749B765EEAD464F.
  - Final key_out = 1D6DBBABCFB7988D8EF912F76883CDC1 with key_round = 10 and key_last = 1.
  - done pulses one cycle after the final key; busy is low in that cycle.
- Decrypt stream: start with decrypt = 1 → first key 1D6DBBAB…CDC1 (round 10), second 9F231CAD…CB36 (round 9), last 54776F20…776F (round 0) with key_last = 1.
- Backpressure: toggle key_ready 1,0,0,1,… → key_out stable while ready = 0, no key skipped or duplicated, still exactly 11 handshakes.
- Mid-sequence events:
  - start pulsed while busy → ignored.
  - rst asserted after the round 4 handshake → next cycle key_valid = 0, busy = 0, no done pulse.
  - A fresh start afterwards restarts from round 0.
- Start in the FIN cycle is ignored; start the following cycle is accepted and yields round 0 after one cycle.
